// File: rtl/uart_fifo.sv
// uart_fifo: TX and RX byte FIFOs between the system bus and the uart serial core.
// Outputs derive only from registered state. A write to a full TX FIFO or a receive into a full RX FIFO is dropped and raises a sticky overflow flag.
module uart_fifo #(
  parameter int TX_AW = 4,
  parameter int RX_AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  input  logic             ovf_clr,
  output logic             tx_full,
  output logic [TX_AW:0]   tx_level,
  output logic             rx_empty,
  output logic [RX_AW:0]   rx_level,
  output logic             tx_ovf,
  output logic             rx_ovf,
  output logic [7:0]       uart_data_in,
  output logic             uart_data_send,
  input  logic             uart_data_sent,
  input  logic [7:0]       uart_data_out,
  input  logic             uart_data_received
);
  localparam int TX_DEPTH = 1 << TX_AW;
  localparam int RX_DEPTH = 1 << RX_AW;

  logic [7:0]     tx_mem [TX_DEPTH];
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [TX_AW:0] tx_wptr, tx_rptr;
  logic [RX_AW:0] rx_wptr, rx_rptr;
  logic           tx_empty, rx_full;
  logic           tx_push, tx_pop, rx_push, rx_pop;

  // Occupancy comes from the extra pointer bit, so full and empty never alias.
  assign tx_level = tx_wptr - tx_rptr;
  assign rx_level = rx_wptr - rx_rptr;
  assign tx_full  = (tx_level == (TX_AW+1)'(TX_DEPTH));
  assign tx_empty = (tx_level == '0);
  assign rx_full  = (rx_level == (RX_AW+1)'(RX_DEPTH));
  assign rx_empty = (rx_level == '0);

  assign tx_push = wr_en && !tx_full;
  assign tx_pop  = uart_data_sent && !tx_empty;
  assign rx_push = uart_data_received && !rx_full;
  assign rx_pop  = rd_en && !rx_empty;

  // Heads are forced to zero when empty so stale array contents never leak out.
  assign uart_data_send = !tx_empty;
  assign uart_data_in   = tx_empty ? 8'h00 : tx_mem[tx_rptr[TX_AW-1:0]];
  assign rd_data        = rx_empty ? 8'h00 : rx_mem[rx_rptr[RX_AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      rx_wptr <= '0;
      rx_rptr <= '0;
      tx_ovf  <= 1'b0;
      rx_ovf  <= 1'b0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + (TX_AW+1)'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + (TX_AW+1)'(1);
      if (rx_push) rx_wptr <= rx_wptr + (RX_AW+1)'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + (RX_AW+1)'(1);
      // Set has priority over clear.
      if (wr_en && tx_full)                   tx_ovf <= 1'b1;
      else if (ovf_clr)                       tx_ovf <= 1'b0;
      if (uart_data_received && rx_full)      rx_ovf <= 1'b1;
      else if (ovf_clr)                       rx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && tx_push) tx_mem[tx_wptr[TX_AW-1:0]] <= wr_data;
    if (!rst && rx_push) rx_mem[rx_wptr[RX_AW-1:0]] <= uart_data_out;
  end
endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo: a queue-based model is compared every cycle, a small core model drains TX,
// and randomized traffic plus directed boundary cases are applied.
module tb_uart_fifo;
  localparam int TXD = 16;
  localparam int RXD = 16;
  localparam int BT  = 2;

  logic       clk = 0, rst = 1;
  logic       wr_en = 0, rd_en = 0, ovf_clr = 0;
  logic [7:0] wr_data = 0, uart_data_out = 0;
  logic       uart_data_sent = 0, uart_data_received = 0;
  logic [7:0] rd_data, uart_data_in;
  logic       tx_full, rx_empty, tx_ovf, rx_ovf, uart_data_send;
  logic [4:0] tx_level, rx_level;

  always #5 clk = ~clk;

  uart_fifo #(.TX_AW(4), .RX_AW(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .ovf_clr(ovf_clr), .tx_full(tx_full), .tx_level(tx_level),
    .rx_empty(rx_empty), .rx_level(rx_level), .tx_ovf(tx_ovf), .rx_ovf(rx_ovf),
    .uart_data_in(uart_data_in), .uart_data_send(uart_data_send),
    .uart_data_sent(uart_data_sent), .uart_data_out(uart_data_out),
    .uart_data_received(uart_data_received)
  );

  int total = 0, bad = 0;
  logic [7:0] tx_q[$], rx_q[$], exp_order[$];
  bit m_txovf = 0, m_rxovf = 0, chk_en = 0;
  bit tf, te, rf, re;
  int core_cnt = 0, core_gap = 0, core_bytes = 0;
  bit core_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain queues updated at each active edge.
  always @(posedge clk) begin
    if (rst) begin
      tx_q.delete(); rx_q.delete(); exp_order.delete();
      m_txovf = 0; m_rxovf = 0; chk_en = 1;
    end else begin
      tf = (tx_q.size() == TXD); te = (tx_q.size() == 0);
      rf = (rx_q.size() == RXD); re = (rx_q.size() == 0);
      if (uart_data_sent && !te) void'(tx_q.pop_front());
      if (wr_en && !tf) begin tx_q.push_back(wr_data); exp_order.push_back(wr_data); end
      if (rd_en && !re) void'(rx_q.pop_front());
      if (uart_data_received && !rf) rx_q.push_back(uart_data_out);
      m_txovf = (wr_en && tf) ? 1'b1 : (ovf_clr ? 1'b0 : m_txovf);
      m_rxovf = (uart_data_received && rf) ? 1'b1 : (ovf_clr ? 1'b0 : m_rxovf);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_level", 32'(tx_level), 32'(tx_q.size()));
      chk("tx_full", 32'(tx_full), 32'(tx_q.size() == TXD));
      chk("uart_data_send", 32'(uart_data_send), 32'(tx_q.size() != 0));
      chk("uart_data_in", 32'(uart_data_in), 32'(tx_q.size() != 0 ? tx_q[0] : 8'h00));
      chk("tx_ovf", 32'(tx_ovf), 32'(m_txovf));
      chk("rx_level", 32'(rx_level), 32'(rx_q.size()));
      chk("rx_empty", 32'(rx_empty), 32'(rx_q.size() == 0));
      chk("rd_data", 32'(rd_data), 32'(rx_q.size() != 0 ? rx_q[0] : 8'h00));
      chk("rx_ovf", 32'(rx_ovf), 32'(m_rxovf));
    end
  end

  // One cycle: core model acts on the current outputs, inputs are applied, one edge passes.
  task automatic tick(input bit w, input logic [7:0] wd, input bit r,
                      input bit rcv, input logic [7:0] rdat, input bit clr);
    logic [7:0] e;
    uart_data_sent = 0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin uart_data_sent = 1; core_gap = 2; end
    end else if (core_gap > 0) begin
      core_gap--;
    end else if (core_en && uart_data_send) begin
      e = (exp_order.size() != 0) ? exp_order.pop_front() : 8'hxx;
      chk("core_byte_order", 32'(uart_data_in), 32'(e));
      core_bytes++;
      core_cnt = 10 * BT;
    end
    wr_en = w; wr_data = wd; rd_en = r;
    uart_data_received = rcv; uart_data_out = rdat; ovf_clr = clr;
    @(posedge clk);
    @(negedge clk);
    wr_en = 0; rd_en = 0; uart_data_received = 0; ovf_clr = 0; uart_data_sent = 0;
  endtask

  task automatic idle();
    tick(0, 8'h00, 0, 0, 8'h00, 0);
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while ((tx_level != 0 || core_cnt != 0 || core_gap != 0) && n < 3000) begin idle(); n++; end
    chk("tx_drain", 32'(tx_level), 32'd0);
  endtask

  task automatic drain_rx();
    int n = 0;
    while (!rx_empty && n < 100) begin tick(0, 8'h00, 1, 0, 8'h00, 0); n++; end
    chk("rx_drain", 32'(rx_empty), 32'd1);
  endtask

  initial begin
    int n, b0;
    bit w;
    @(negedge clk);
    idle(); idle();
    rst = 0;
    chk("rst_tx_level", 32'(tx_level), 32'd0);
    chk("rst_rx_empty", 32'(rx_empty), 32'd1);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_send", 32'(uart_data_send), 32'd0);

    // Three bytes through the core.
    core_en = 1;
    tick(1, 8'h41, 0, 0, 8'h00, 0);
    chk("tx_first_head", 32'(uart_data_in), 32'h41);
    tick(1, 8'h42, 0, 0, 8'h00, 0);
    tick(1, 8'h43, 0, 0, 8'h00, 0);
    chk("tx_level3", 32'(tx_level), 32'd3);
    wait_tx_idle();
    chk("tx_three_sent", 32'(core_bytes), 32'd3);

    // Fill TX with the core stalled, then overflow.
    core_en = 0;
    for (int i = 0; i < TXD; i++) tick(1, 8'(i), 0, 0, 8'h00, 0);
    chk("tx_full_lit", 32'(tx_full), 32'd1);
    chk("tx_level16", 32'(tx_level), 32'd16);
    tick(1, 8'hFF, 0, 0, 8'h00, 0);
    chk("tx_ovf_lit", 32'(tx_ovf), 32'd1);
    chk("tx_level_after_drop", 32'(tx_level), 32'd16);
    tick(0, 8'h00, 0, 0, 8'h00, 1);
    chk("tx_ovf_clr", 32'(tx_ovf), 32'd0);
    core_en = 1;
    wait_tx_idle();

    // RX fill and overflow, then ordered drain.
    for (int i = 0; i < RXD; i++) tick(0, 8'h00, 0, 1, 8'(8'h10 + i), 0);
    tick(0, 8'h00, 0, 1, 8'h20, 0);
    chk("rx_level16", 32'(rx_level), 32'd16);
    chk("rx_ovf_lit", 32'(rx_ovf), 32'd1);
    for (int i = 0; i < RXD; i++) begin
      chk("rx_pop_order", 32'(rd_data), 32'h10 + 32'(i));
      tick(0, 8'h00, 1, 0, 8'h00, 0);
    end
    chk("rx_empty_lit", 32'(rx_empty), 32'd1);
    chk("rx_empty_data", 32'(rd_data), 32'd0);
    tick(0, 8'h00, 0, 0, 8'h00, 1);

    // Simultaneous push and pop at level 3.
    tick(0, 8'h00, 0, 1, 8'hA1, 0);
    tick(0, 8'h00, 0, 1, 8'hA2, 0);
    tick(0, 8'h00, 0, 1, 8'hA3, 0);
    tick(0, 8'h00, 1, 1, 8'h5A, 0);
    chk("rx_same_level", 32'(rx_level), 32'd3);
    chk("rx_same_head", 32'(rd_data), 32'hA2);
    tick(0, 8'h00, 1, 0, 8'h00, 0);
    tick(0, 8'h00, 1, 0, 8'h00, 0);
    chk("rx_same_tail", 32'(rd_data), 32'h5A);
    drain_rx();

    // 40 bytes streamed with the level held below full, wrapping the pointers.
    b0 = core_bytes; n = 0;
    for (int c = 0; c < 3000 && (n < 40 || tx_level != 0 || core_cnt != 0); c++) begin
      w = (n < 40) && (tx_level < 15) && ($urandom_range(0, 1) == 1);
      tick(w, 8'($urandom), 0, 0, 8'h00, 0);
      if (w) n++;
    end
    chk("tx_stream_count", 32'(core_bytes - b0), 32'd40);

    // Random mixed traffic.
    for (int c = 0; c < 800; c++)
      tick($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 19) == 0);
    wait_tx_idle();
    drain_rx();
    tick(0, 8'h00, 0, 0, 8'h00, 1);

    // Reset with both FIFOs populated and rx_ovf set.
    core_en = 0;
    for (int i = 0; i < 5; i++) tick(1, 8'(8'hC0 + i), 0, 0, 8'h00, 0);
    for (int i = 0; i < RXD + 1; i++) tick(0, 8'h00, 0, 1, 8'(i), 0);
    for (int i = 0; i < RXD - 2; i++) tick(0, 8'h00, 1, 0, 8'h00, 0);
    chk("pre_rst_tx_level", 32'(tx_level), 32'd5);
    chk("pre_rst_rx_level", 32'(rx_level), 32'd2);
    chk("pre_rst_rx_ovf", 32'(rx_ovf), 32'd1);
    rst = 1;
    idle();
    rst = 0;
    chk("post_rst_tx_level", 32'(tx_level), 32'd0);
    chk("post_rst_rx_level", 32'(rx_level), 32'd0);
    chk("post_rst_rx_ovf", 32'(rx_ovf), 32'd0);
    chk("post_rst_send", 32'(uart_data_send), 32'd0);
    chk("post_rst_data_in", 32'(uart_data_in), 32'd0);
    chk("post_rst_rd_data", 32'(rd_data), 32'd0);
    tick(1, 8'h77, 0, 0, 8'h00, 0);
    chk("post_rst_write", 32'(uart_data_in), 32'h77);
    chk("post_rst_write_send", 32'(uart_data_send), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
